comp2: RTL and testbench
========================

// Module: comp2
// PURPOSE
// - Registered 2-bit magnitude comparator with outcome statistics.
// - Operand A = {ina,inb} (ina = MSB); operand B = {inc,ind} (inc = MSB).
// - Flags: A>B (outf1), A==B (outf2), A<B (outf3).
// - Standalone datapath leaf; flags are consumed by downstream control logic.
// - Saturating outcome counters give the consumer cheap observability.
// PARAMETERS
// - CNT_W  8  width of each saturating outcome counter (legal range 1..16)
// PORTS
// - clk       in   1      system clock; all state updates on its rising edge
// - rst_n     in   1      asynchronous active-low reset
// - ina       in   1      A[1], operand A MSB
// - inb       in   1      A[0], operand A LSB
// - inc       in   1      B[1], operand B MSB
// - ind       in   1      B[0], operand B LSB
// - clr_cnt   in   1      synchronous clear of the three counters
// - outf1     out  1      registered A>B flag
// - outf2     out  1      registered A==B flag
// - outf3     out  1      registered A<B flag
// - out_valid out  1      high once the flags hold a sampled result
// - gt_cnt    out  CNT_W  number of sampled cycles with A>B
// - eq_cnt    out  CNT_W  number of sampled cycles with A==B
// - lt_cnt    out  CNT_W  number of sampled cycles with A<B
// BEHAVIOUR
// - Reset: one clock, asynchronous active-low reset. While rst_n=0:
//   outf1..3=0, out_valid=0, all counters=0.
// - Deassertion: rst_n deassertion is synchronised internally through a
//   2-flop release. The first sample is taken on the first rising edge with
//   released reset.
// - Comparison: unsigned 2-bit magnitude compare, A and B in 0..3.
//   - A>B sets outf1, A==B sets outf2, A<B sets outf3.
// - Latency: inputs are sampled on every rising clk edge; flags update on that
//   same edge, i.e. 1-cycle latency. There is no input handshake; every cycle
//   is a sample.
// - Exclusivity: when out_valid=1, exactly one of outf1..3 is 1. Flags are
//   never 000 after the first sample and never multi-hot.
// - out_valid: 0 after reset; becomes 1 on the first sampling edge and stays 1
//   until the next reset.
// - Counters:
//   - On each sampling edge, the counter matching the new outcome increments
//     by 1.
//   - Each counter saturates at 2^CNT_W-1; there is no wrap.
// - clr_cnt:
//   - If clr_cnt=1 at an edge, all counters load 0 and the current outcome is
//     NOT counted. Flags still update normally.
//   - clr_cnt has no effect on the flags or on out_valid.
// - Reset mid-operation: asserting rst_n clears everything immediately, with
//   no clock needed. Counting restarts from 0.
// - Input timing: inputs are synchronous to clk. Asynchronous sources must be
//   synchronised upstream; the block adds no input synchronisers.
// TESTING
// 1. Reset: hold rst_n=0 with inputs toggling.
//    -> outf1..3=000, out_valid=0, counters 0, with no clock activity.
// 2. Exhaustive compare: sweep all 16 {ina,inb,inc,ind} combinations, one per
//    cycle. Expected flags one cycle later, e.g.:
//    - A=2,B=1 -> 100
//    - A=3,B=3 -> 010
//    - A=0,B=2 -> 001
// 3. Counters after the 16-cycle sweep: gt_cnt=6, eq_cnt=4, lt_cnt=6.
//    Exactly one flag is high on every valid cycle.
// 4. Saturation: CNT_W=4, hold A=1,B=1 for 20 cycles.
//    -> eq_cnt=15 and stays 15; gt_cnt=lt_cnt=0.
// 5. Counter clear: pulse clr_cnt for one cycle with A=3,B=0.
//    -> all counters 0 after that edge; the next edge gives gt_cnt=1;
//       outf1=1 throughout.
// 6. Mid-run reset: assert rst_n low between edges during the sweep.
//    -> outputs clear asynchronously. After release, out_valid reasserts on
//       the first sampling edge.

Source files
------------

// File: rtl/comp2.sv
// comp2: registered 2-bit magnitude comparator with saturating outcome counters
module comp2 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ina,
  input  logic             inb,
  input  logic             inc,
  input  logic             ind,
  input  logic             clr_cnt,
  output logic             outf1,
  output logic             outf2,
  output logic             outf3,
  output logic             out_valid,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt
);
  logic [1:0] rs;
  logic gt, eq, lt;
  assign gt = {ina, inb} > {inc, ind};
  assign eq = {ina, inb} == {inc, ind};
  assign lt = {ina, inb} < {inc, ind};
  // reset asserts immediately but releases only after two clean edges
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rs <= 2'b00;
    else rs <= {rs[0], 1'b1};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {outf1, outf2, outf3, out_valid} <= 4'b0000;
      gt_cnt <= '0;
      eq_cnt <= '0;
      lt_cnt <= '0;
    end else if (rs[1]) begin
      {outf1, outf2, outf3} <= {gt, eq, lt};
      out_valid <= 1'b1;
      gt_cnt <= clr_cnt ? '0 : (gt && gt_cnt != '1) ? gt_cnt + 1'b1 : gt_cnt;
      eq_cnt <= clr_cnt ? '0 : (eq && eq_cnt != '1) ? eq_cnt + 1'b1 : eq_cnt;
      lt_cnt <= clr_cnt ? '0 : (lt && lt_cnt != '1) ? lt_cnt + 1'b1 : lt_cnt;
    end
endmodule

// File: tb/tb_comp2.sv
// tb_comp2: scoreboard bench for comp2 at CNT_W=8 and CNT_W=4 sharing one stimulus stream
module tb_comp2;
  logic clk = 0, rst_n = 0, ina = 0, inb = 0, inc = 0, ind = 0, clr_cnt = 0;
  logic f1a, f2a, f3a, va, f1b, f2b, f3b, vb;
  logic [7:0] gta, eqa, lta;
  logic [3:0] gtb, eqb, ltb;
  int n_cmp = 0, n_bad = 0;
  int m8 [3], m4 [3];
  typedef struct { logic [1:0] a, b; logic clr; } stim_t;
  stim_t q [$];

  always #5 clk = ~clk;

  comp2 #(.CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .ina(ina), .inb(inb), .inc(inc), .ind(ind),
    .clr_cnt(clr_cnt), .outf1(f1a), .outf2(f2a), .outf3(f3a), .out_valid(va),
    .gt_cnt(gta), .eq_cnt(eqa), .lt_cnt(lta));
  comp2 #(.CNT_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .ina(ina), .inb(inb), .inc(inc), .ind(ind),
    .clr_cnt(clr_cnt), .outf1(f1b), .outf2(f2b), .outf3(f3b), .out_valid(vb),
    .gt_cnt(gtb), .eq_cnt(eqb), .lt_cnt(ltb));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " flags8"}, {f1a, f2a, f3a, va}, 0);
    chk({tag, " flags4"}, {f1b, f2b, f3b, vb}, 0);
    chk({tag, " cnt8"}, {gta, eqa, lta}, 0);
    chk({tag, " cnt4"}, {gtb, eqb, ltb}, 0);
  endtask

  task automatic step(input logic [1:0] a, input logic [1:0] b, input logic clr);
    stim_t s, e;
    logic [2:0] ef;
    s.a = a; s.b = b; s.clr = clr;
    {ina, inb, inc, ind, clr_cnt} = {a, b, clr};
    q.push_back(s);
    @(negedge clk);
    e = q.pop_front();
    ef = {e.a > e.b, e.a == e.b, e.a < e.b};
    for (int i = 0; i < 3; i++) begin
      m8[i] = e.clr ? 0 : (ef[2-i] && m8[i] < 255) ? m8[i] + 1 : m8[i];
      m4[i] = e.clr ? 0 : (ef[2-i] && m4[i] < 15) ? m4[i] + 1 : m4[i];
    end
    chk($sformatf("flags8 %0d?%0d", e.a, e.b), {va, f1a, f2a, f3a}, {1'b1, ef});
    chk($sformatf("flags4 %0d?%0d", e.a, e.b), {vb, f1b, f2b, f3b}, {1'b1, ef});
    chk("onehot", 32'($onehot({f1a, f2a, f3a})), 1);
    chk("cnt8", {gta, eqa, lta}, {8'(m8[0]), 8'(m8[1]), 8'(m8[2])});
    chk("cnt4", {gtb, eqb, ltb}, {4'(m4[0]), 4'(m4[1]), 4'(m4[2])});
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("sync1 valid", {va, vb}, 0);
    @(negedge clk);
    chk("sync2 valid", {va, vb}, 0);
  endtask

  initial begin
    foreach (m8[i]) begin m8[i] = 0; m4[i] = 0; end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      {ina, inb, inc, ind} = 4'($urandom);
      #1 chk_idle("in reset");
    end
    release_rst();
    for (int i = 0; i < 16; i++) step(i[3:2], i[1:0], 0);
    chk("sweep gt", gta, 6);
    chk("sweep eq", eqa, 4);
    chk("sweep lt", lta, 6);
    step(2'd1, 2'd1, 1);
    for (int i = 0; i < 20; i++) step(2'd1, 2'd1, 0);
    chk("sat eq4", eqb, 15);
    chk("nosat eq8", eqa, 20);
    step(2'd3, 2'd0, 1);
    chk("clr gt", gta, 0);
    step(2'd3, 2'd0, 0);
    chk("after clr gt", gta, 1);
    chk("after clr outf1", f1a, 1);
    for (int i = 0; i < 7; i++) step(i[3:2], i[1:0], 0);
    @(posedge clk);
    #2 rst_n = 0;
    #1 chk_idle("async rst");
    q.delete();
    foreach (m8[i]) begin m8[i] = 0; m4[i] = 0; end
    release_rst();
    for (int i = 15; i >= 0; i--) step(i[3:2], i[1:0], 0);
    chk("resweep eq", eqa, 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
